// File: rtl/clk_div_bank_if.sv
// Request/status bundle for clk_div_bank: per-channel mode requests in,
// generated square waves and mode status out.
interface clk_div_bank_if #(
  parameter int NCH    = 2,
  parameter int PROG_W = 3
) ();

  logic [NCH-1:0]        update;
  logic [NCH*PROG_W-1:0] prog_in;
  logic                  clk_fast;
  logic [NCH-1:0]        clk_slow;
  logic [NCH*PROG_W-1:0] prog_out;
  logic [NCH-1:0]        pending;

  modport master (
    output update, prog_in,
    input  clk_fast, clk_slow, prog_out, pending
  );

  modport slave (
    input  update, prog_in,
    output clk_fast, clk_slow, prog_out, pending
  );

endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock generator: one fast square wave plus NCH slow waves at fast/2^mode,
// with glitch-free mode changes. Define DCM_SYNC_IN_EN to add a 2-flop synchronizer on update.
module clk_div_bank #(
  parameter int BASE_HALF = 5_000_000,
  parameter int NCH       = 2,
  parameter int PROG_W    = 3,
  parameter int RST_MODE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_bank_if.slave bus
);

  localparam int CNT_W = (BASE_HALF > 1) ? $clog2(BASE_HALF) : 1;
  localparam int H_W   = (1 << PROG_W) - 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BASE_HALF - 1);
  localparam logic [PROG_W-1:0] MODE_RST = PROG_W'(RST_MODE);

  typedef logic [PROG_W-1:0] mode_t;
  typedef logic [H_W-1:0]    hcnt_t;

  // Shared timebase
  logic [CNT_W-1:0] base_cnt;
  logic             tick;
  logic             fast_q;

  // Request path
  logic [NCH-1:0] upd_s;
  logic [NCH-1:0] upd_q;
  logic [NCH-1:0] rise;

  // Per-channel state and decode
  mode_t [NCH-1:0] mode_q;
  mode_t [NCH-1:0] pend_mode_q;
  mode_t [NCH-1:0] req_mode;
  hcnt_t [NCH-1:0] h_q;
  hcnt_t [NCH-1:0] h_end;
  logic  [NCH-1:0] slow_q;
  logic  [NCH-1:0] pend_q;
  logic  [NCH-1:0] h_last;
  logic  [NCH-1:0] toggle;
  logic  [NCH-1:0] apply;

  // ---------------------------------------------------------------------------
  // Base counter and fast clock
  // ---------------------------------------------------------------------------
  assign tick = (base_cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_cnt <= '0;
      fast_q   <= 1'b0;
    end else if (tick) begin
      base_cnt <= '0;
      fast_q   <= ~fast_q;
    end else begin
      base_cnt <= base_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Request synchronisation and rising-edge detection
  // ---------------------------------------------------------------------------
`ifdef DCM_SYNC_IN_EN
  logic [NCH-1:0] sync_1;
  logic [NCH-1:0] sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= bus.update;
      sync_2 <= sync_1;
    end
  end

  assign upd_s = sync_2;
`else
  assign upd_s = bus.update;
`endif

  // upd_q resets low, so an update held high across reset still counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q <= '0;
    end else begin
      upd_q <= upd_s;
    end
  end

  assign rise = upd_s & ~upd_q;

  // ---------------------------------------------------------------------------
  // Per-channel decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is written for every channel on every
  // evaluation, so no path can leave a stale value and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req_mode[i] = bus.prog_in[i*PROG_W +: PROG_W];
      h_end[i]    = ~({H_W{1'b1}} << mode_q[i]);
      h_last[i]   = (h_q[i] == h_end[i]);
      toggle[i]   = tick & h_last[i];
      apply[i]    = toggle[i] & slow_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel counters, outputs and mode hand-over
  // ---------------------------------------------------------------------------
  // NOTE: the pending-mode registers are reset along with everything else;
  // pending is cleared on reset, but a defined value keeps reset state fully
  // deterministic and costs nothing for a handful of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q         <= '0;
      slow_q      <= '0;
      pend_q      <= '0;
      pend_mode_q <= '0;
      mode_q      <= {NCH{MODE_RST}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (tick) begin
          if (h_last[i]) begin
            slow_q[i] <= ~slow_q[i];
            h_q[i]    <= '0;
          end else begin
            h_q[i] <= h_q[i] + H_W'(1);
          end
        end

        // A mode only changes on the high-to-low edge, so the new half-period
        // always starts from a clean low phase.
        if (apply[i]) begin
          if (rise[i]) begin
            mode_q[i] <= req_mode[i];
          end else if (pend_q[i]) begin
            mode_q[i] <= pend_mode_q[i];
          end
          pend_q[i] <= 1'b0;
        end else if (rise[i]) begin
          pend_mode_q[i] <= req_mode[i];
          pend_q[i]      <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.clk_fast = fast_q;
  assign bus.clk_slow = slow_q;
  assign bus.prog_out = mode_q;
  assign bus.pending  = pend_q;

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_inv
    a_h_in_range : assert property (@(posedge clk) disable iff (rst)
      h_q[g] <= h_end[g]);

    a_apply_clears_pending : assert property (@(posedge clk) disable iff (rst)
      apply[g] |=> !pend_q[g]);

    a_slow_only_on_tick : assert property (@(posedge clk) disable iff (rst)
      !tick |=> $stable(slow_q[g]));
  end

  a_fast_only_on_tick : assert property (@(posedge clk) disable iff (rst)
    !tick |=> $stable(fast_q));

endmodule
